// File: rtl/common_types_pkg.sv
// Shared AHB-Lite types for the datapath-to-bus bridge.
// Enum literals carry a type prefix so the IDLE encodings of HTRANS and the FSM can coexist.
package common_types_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_t;

  typedef enum logic [1:0] {
    AHBM_IDLE,
    AHBM_ADDR,
    AHBM_DATA
  } ahbm_state_t;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // One latched bus request: everything the address and data phases need.
  typedef struct packed {
    logic [31:0] addr;
    hsize_t      size;
    logic        write;
    logic        is_data;
    logic [31:0] wdata;
  } ahbm_req_t;

endpackage

// File: rtl/ahb_master_if.sv
// Datapath-side request/response bundle for the AHB-Lite master bridge.
interface ahb_master_if;

  logic        iread;
  logic        dread;
  logic [1:0]  dwrite;
  logic [31:0] iaddr;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        ihit;
  logic        dhit;
  logic [31:0] iload;
  logic [31:0] dload;

  modport ahb_master (
    input  iread, dread, dwrite, iaddr, daddr, dstore,
    output ihit, dhit, iload, dload
  );

  modport datapath (
    output iread, dread, dwrite, iaddr, daddr, dstore,
    input  ihit, dhit, iload, dload
  );

endinterface

// File: rtl/ahb_lite_master.sv
// Instruction/data request arbiter driving one non-overlapped AHB-Lite single transfer at a time.
// Optional AHB_ERR_CAPTURE_EN adds sticky bus_err / bus_err_addr error capture.
module ahb_lite_master
  import common_types_pkg::*;
#(
  parameter int DATA_PRIORITY = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  ahb_master_if.ahb_master     amif,
  output logic [31:0]          HADDR,
  output logic [1:0]           HTRANS,
  output logic [2:0]           HSIZE,
  output logic [2:0]           HBURST,
  output logic                 HWRITE,
  output logic [31:0]          HWDATA,
  input  logic [31:0]          HRDATA,
  input  logic                 HREADY,
  input  logic                 HRESP
`ifdef AHB_ERR_CAPTURE_EN
  ,
  output logic                 bus_err,
  output logic [31:0]          bus_err_addr
`endif
);

  ahbm_state_t state_q;
  htrans_t     htrans_q;
  ahbm_req_t   req_q;
  ahbm_req_t   req_d;
  logic [31:0] hwdata_q;

  logic d_req;
  logic i_req;
  logic pick_data;
  logic complete;

  // Arbitration and lane replication for the request that would be latched this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    req_d     = '0;
    d_req     = amif.dread || (amif.dwrite != 2'b00);
    i_req     = amif.iread;
    pick_data = d_req && (!i_req || (DATA_PRIORITY != 0));

    if (pick_data) begin
      req_d.addr    = amif.daddr;
      req_d.is_data = 1'b1;
      case (amif.dwrite)
        2'b01: begin
          req_d.size  = HSIZE_BYTE;
          req_d.write = 1'b1;
          req_d.wdata = {4{amif.dstore[7:0]}};
        end
        2'b10: begin
          req_d.size  = HSIZE_HALF;
          req_d.write = 1'b1;
          req_d.wdata = {2{amif.dstore[15:0]}};
        end
        2'b11: begin
          req_d.size  = HSIZE_WORD;
          req_d.write = 1'b1;
          req_d.wdata = amif.dstore;
        end
        default: begin
          req_d.size  = HSIZE_WORD;
          req_d.write = 1'b0;
          req_d.wdata = '0;
        end
      endcase
    end else begin
      req_d.addr    = amif.iaddr;
      req_d.size    = HSIZE_WORD;
      req_d.write   = 1'b0;
      req_d.is_data = 1'b0;
      req_d.wdata   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= AHBM_IDLE;
      htrans_q <= HTRANS_IDLE;
      req_q    <= '0;
      hwdata_q <= '0;
    end else begin
      case (state_q)
        AHBM_IDLE: begin
          if (d_req || i_req) begin
            state_q  <= AHBM_ADDR;
            htrans_q <= HTRANS_NONSEQ;
            req_q    <= req_d;
          end
        end
        AHBM_ADDR: begin
          if (HREADY) begin
            state_q  <= AHBM_DATA;
            htrans_q <= HTRANS_IDLE;
            hwdata_q <= req_q.wdata;
          end
        end
        AHBM_DATA: begin
          if (HREADY) begin
            state_q <= AHBM_IDLE;
          end
        end
        default: begin
          state_q  <= AHBM_IDLE;
          htrans_q <= HTRANS_IDLE;
        end
      endcase
    end
  end

  // An error response ends with HREADY high, so it completes like any other transfer.
  assign complete = (state_q == AHBM_DATA) && HREADY;

  assign amif.ihit  = complete && !req_q.is_data;
  assign amif.dhit  = complete &&  req_q.is_data;
  assign amif.iload = (amif.ihit && !HRESP) ? HRDATA : '0;
  assign amif.dload = (amif.dhit && !HRESP) ? HRDATA : '0;

  assign HADDR  = req_q.addr;
  assign HTRANS = htrans_q;
  assign HSIZE  = req_q.size;
  assign HBURST = HBURST_SINGLE;
  assign HWRITE = req_q.write;
  assign HWDATA = hwdata_q;

`ifdef AHB_ERR_CAPTURE_EN
  logic        bus_err_q;
  logic [31:0] bus_err_addr_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus_err_q      <= 1'b0;
      bus_err_addr_q <= '0;
    end else if (complete && HRESP) begin
      bus_err_q      <= 1'b1;
      bus_err_addr_q <= req_q.addr;
    end
  end

  assign bus_err      = bus_err_q;
  assign bus_err_addr = bus_err_addr_q;
`endif

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed self-checking bench for ahb_lite_master: fetch, writes, arbitration, wait states, error, reset abort.
module tb_ahb_lite_master;

  logic        CLK;
  logic        RST;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
`ifdef AHB_ERR_CAPTURE_EN
  logic        bus_err;
  logic [31:0] bus_err_addr;
`endif

  int n_cmp;
  int n_err;

  ahb_master_if amif ();

  ahb_lite_master #(.DATA_PRIORITY(1)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .amif   (amif),
    .HADDR  (HADDR),
    .HTRANS (HTRANS),
    .HSIZE  (HSIZE),
    .HBURST (HBURST),
    .HWRITE (HWRITE),
    .HWDATA (HWDATA),
    .HRDATA (HRDATA),
    .HREADY (HREADY),
    .HRESP  (HRESP)
`ifdef AHB_ERR_CAPTURE_EN
    ,
    .bus_err      (bus_err),
    .bus_err_addr (bus_err_addr)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    RST = 1'b1;
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP = 1'b0;
    amif.iread = 1'b0;
    amif.dread = 1'b0;
    amif.dwrite = 2'b00;
    amif.iaddr = '0;
    amif.daddr = '0;
    amif.dstore = '0;

    tick();
    tick();
    #1;
    check("rst_htrans", 32'(HTRANS), 32'h0);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hsize", 32'(HSIZE), 32'h0);
    check("rst_hwrite", 32'(HWRITE), 32'h0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_hburst", 32'(HBURST), 32'h0);
    check("rst_ihit", 32'(amif.ihit), 32'h0);
    check("rst_dhit", 32'(amif.dhit), 32'h0);
    check("rst_iload", amif.iload, 32'h0);
    RST = 1'b0;

    // Instruction fetch, zero wait states.
    tick();
    amif.iread = 1'b1;
    amif.iaddr = 32'h0000_0100;
    HRDATA = 32'hDEAD_BEEF;
    #1;
    check("if_n_htrans", 32'(HTRANS), 32'h0);
    check("if_n_iload", amif.iload, 32'h0);
    tick();
    #1;
    check("if_n1_htrans", 32'(HTRANS), 32'h2);
    check("if_n1_haddr", HADDR, 32'h0000_0100);
    check("if_n1_hsize", 32'(HSIZE), 32'h2);
    check("if_n1_hwrite", 32'(HWRITE), 32'h0);
    check("if_n1_ihit", 32'(amif.ihit), 32'h0);
    tick();
    #1;
    check("if_n2_ihit", 32'(amif.ihit), 32'h1);
    check("if_n2_dhit", 32'(amif.dhit), 32'h0);
    check("if_n2_iload", amif.iload, 32'hDEAD_BEEF);
    check("if_n2_htrans", 32'(HTRANS), 32'h0);
    amif.iread = 1'b0;
    tick();
    #1;
    check("if_n3_ihit", 32'(amif.ihit), 32'h0);
    check("if_n3_iload", amif.iload, 32'h0);

    // Byte store with lane replication.
    amif.dwrite = 2'b01;
    amif.daddr = 32'h0000_2003;
    amif.dstore = 32'h0000_00A5;
    tick();
    #1;
    check("sb_htrans", 32'(HTRANS), 32'h2);
    check("sb_hwrite", 32'(HWRITE), 32'h1);
    check("sb_hsize", 32'(HSIZE), 32'h0);
    check("sb_haddr", HADDR, 32'h0000_2003);
    tick();
    #1;
    check("sb_dhit", 32'(amif.dhit), 32'h1);
    check("sb_hwdata", HWDATA, 32'hA5A5_A5A5);
    amif.dwrite = 2'b00;
    tick();
    #1;
    check("sb_dhit_gone", 32'(amif.dhit), 32'h0);

    // Halfword store with dread also high: write wins, one dhit.
    amif.dwrite = 2'b10;
    amif.dread = 1'b1;
    amif.daddr = 32'h0000_2402;
    amif.dstore = 32'h1234_5678;
    tick();
    #1;
    check("sh_hwrite", 32'(HWRITE), 32'h1);
    check("sh_hsize", 32'(HSIZE), 32'h1);
    tick();
    #1;
    check("sh_dhit", 32'(amif.dhit), 32'h1);
    check("sh_hwdata", HWDATA, 32'h5678_5678);
    amif.dwrite = 2'b00;
    amif.dread = 1'b0;
    tick();
    #1;
    check("sh_htrans_idle", 32'(HTRANS), 32'h0);

    // Simultaneous fetch and load: data first.
    amif.iread = 1'b1;
    amif.iaddr = 32'h0000_0104;
    amif.dread = 1'b1;
    amif.daddr = 32'h0000_3000;
    HRDATA = 32'h1111_2222;
    tick();
    #1;
    check("arb_n1_haddr", HADDR, 32'h0000_3000);
    check("arb_n1_hwrite", 32'(HWRITE), 32'h0);
    tick();
    #1;
    check("arb_n2_dhit", 32'(amif.dhit), 32'h1);
    check("arb_n2_ihit", 32'(amif.ihit), 32'h0);
    check("arb_n2_dload", amif.dload, 32'h1111_2222);
    check("arb_n2_iload", amif.iload, 32'h0);
    amif.dread = 1'b0;
    tick();
    #1;
    check("arb_n3_htrans", 32'(HTRANS), 32'h0);
    check("arb_n3_ihit", 32'(amif.ihit), 32'h0);
    tick();
    HRDATA = 32'h3333_4444;
    #1;
    check("arb_n4_htrans", 32'(HTRANS), 32'h2);
    check("arb_n4_haddr", HADDR, 32'h0000_0104);
    tick();
    #1;
    check("arb_n5_ihit", 32'(amif.ihit), 32'h1);
    check("arb_n5_iload", amif.iload, 32'h3333_4444);
    amif.iread = 1'b0;
    tick();

    // Word store with three data-phase wait states.
    amif.dwrite = 2'b11;
    amif.daddr = 32'h0000_5000;
    amif.dstore = 32'hCAFE_F00D;
    tick();
    #1;
    check("ws_hsize", 32'(HSIZE), 32'h2);
    tick();
    HREADY = 1'b0;
    #1;
    check("ws_n2_dhit", 32'(amif.dhit), 32'h0);
    check("ws_n2_hwdata", HWDATA, 32'hCAFE_F00D);
    tick();
    #1;
    check("ws_n3_dhit", 32'(amif.dhit), 32'h0);
    check("ws_n3_hwdata", HWDATA, 32'hCAFE_F00D);
    tick();
    #1;
    check("ws_n4_dhit", 32'(amif.dhit), 32'h0);
    check("ws_n4_hwdata", HWDATA, 32'hCAFE_F00D);
    tick();
    HREADY = 1'b1;
    #1;
    check("ws_n5_dhit", 32'(amif.dhit), 32'h1);
    check("ws_n5_hwdata", HWDATA, 32'hCAFE_F00D);
    amif.dwrite = 2'b00;
    tick();
    #1;
    check("ws_after_dhit", 32'(amif.dhit), 32'h0);

    // Error response on a load.
    amif.dread = 1'b1;
    amif.daddr = 32'h4000_0000;
    HRDATA = 32'hFFFF_FFFF;
    tick();
    #1;
    check("err_haddr", HADDR, 32'h4000_0000);
    tick();
    HREADY = 1'b0;
    HRESP = 1'b1;
    #1;
    check("err_c1_dhit", 32'(amif.dhit), 32'h0);
    tick();
    HREADY = 1'b1;
    #1;
    check("err_c2_dhit", 32'(amif.dhit), 32'h1);
    check("err_c2_dload", amif.dload, 32'h0);
    amif.dread = 1'b0;
    tick();
    HRESP = 1'b0;
    #1;
    check("err_after_dhit", 32'(amif.dhit), 32'h0);
`ifdef AHB_ERR_CAPTURE_EN
    check("err_bus_err", 32'(bus_err), 32'h1);
    check("err_bus_err_addr", bus_err_addr, 32'h4000_0000);
`endif

    // Reset asserted while in the address phase.
    amif.iread = 1'b1;
    amif.iaddr = 32'h0000_0200;
    HRDATA = 32'h5555_AAAA;
    tick();
    #1;
    check("ra_pre_htrans", 32'(HTRANS), 32'h2);
    RST = 1'b1;
    #1;
    check("ra_async_htrans", 32'(HTRANS), 32'h0);
    check("ra_async_haddr", HADDR, 32'h0);
    tick();
    #1;
    check("ra_no_ihit", 32'(amif.ihit), 32'h0);
`ifdef AHB_ERR_CAPTURE_EN
    check("ra_bus_err_clr", 32'(bus_err), 32'h0);
`endif
    RST = 1'b0;
    tick();
    #1;
    check("ra_fresh_htrans", 32'(HTRANS), 32'h2);
    check("ra_fresh_haddr", HADDR, 32'h0000_0200);
    tick();
    #1;
    check("ra_fresh_ihit", 32'(amif.ihit), 32'h1);
    check("ra_fresh_iload", amif.iload, 32'h5555_AAAA);
    amif.iread = 1'b0;
    tick();
    #1;
    check("ra_end_ihit", 32'(amif.ihit), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
